// File: rtl/fetch_pc_sequencer.sv
// Two-wide fetch next-PC controller.
// Holds the bundle PC, predicts conditional branches in either slot with a
// 2-bit BHT, and applies execute redirects and BHT training.
module fetch_pc_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BHT_IDX_W = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fetch_ready,
    input  logic        br0_en,
    input  logic [31:0] br0_imm,
    input  logic        br1_en,
    input  logic [31:0] br1_imm,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    output logic [31:0] pc,
    output logic        fetch_valid,
    output logic        slot1_valid,
    output logic        pred_taken0,
    output logic        pred_taken1
);
    localparam int NE = 1 << BHT_IDX_W;

    typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

    state_t                 state_q, state_d;
    logic [31:0]            pc_d;
    logic [31:0]            pc_p4;
    logic [NE-1:0][1:0]     bht;
    logic [BHT_IDX_W-1:0]   idx0, idx1, uidx;
    logic [1:0]             bht0, bht1;

    // Address bits that never reach the BHT index or the aligned redirect.
    logic unused_bits;
    assign unused_bits = ^{upd_pc[31:BHT_IDX_W+2], upd_pc[1:0], redirect_pc[1:0]};

    assign pc_p4 = pc + 32'd4;
    assign idx0  = pc[BHT_IDX_W+1:2];
    assign idx1  = pc_p4[BHT_IDX_W+1:2];
    assign uidx  = upd_pc[BHT_IDX_W+1:2];
    assign bht0  = bht[idx0];
    assign bht1  = bht[idx1];

    // Bundle is only presented in RUN; predictions are masked otherwise.
    // Slot 1 never predicts when slot 0 already diverts the bundle.
    always_comb begin
        fetch_valid = (state_q == RUN);
        pred_taken0 = fetch_valid & br0_en & bht0[1];
        pred_taken1 = fetch_valid & br1_en & bht1[1] & ~pred_taken0;
        slot1_valid = fetch_valid & ~pred_taken0;
    end

    // Next state and next PC; redirect wins over everything, including stall.
    always_comb begin
        state_d = state_q;
        pc_d    = pc;
        case (state_q)
            BOOT:    state_d = RUN;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
        if (redirect_valid) begin
            state_d = FLUSH;
            pc_d    = {redirect_pc[31:2], 2'b00};
        end else if (state_q != RUN || !fetch_ready) begin
            pc_d = pc;
        end else if (pred_taken0) begin
            pc_d = pc + br0_imm;
        end else if (pred_taken1) begin
            pc_d = pc_p4 + br1_imm;
        end else begin
            pc_d = pc + 32'd8;
        end
    end

    // State and PC registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= BOOT;
            pc      <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc      <= pc_d;
        end
    end

    // BHT training: saturating 2-bit counters; lookups see the pre-update value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NE; i++) bht[i] <= 2'b01;
        end else if (upd_valid) begin
            if (upd_taken) begin
                if (bht[uidx] != 2'b11) bht[uidx] <= bht[uidx] + 2'b01;
            end else begin
                if (bht[uidx] != 2'b00) bht[uidx] <= bht[uidx] - 2'b01;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_sequencer.sv
// Directed self-checking bench for fetch_pc_sequencer.
module tb_fetch_pc_sequencer;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_ready;
    logic        br0_en, br1_en;
    logic [31:0] br0_imm, br1_imm;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        upd_valid, upd_taken;
    logic [31:0] upd_pc;
    logic [31:0] pc;
    logic        fetch_valid, slot1_valid, pred_taken0, pred_taken1;

    int errs   = 0;
    int checks = 0;

    fetch_pc_sequencer #(.RESET_PC(32'h0000_0100), .BHT_IDX_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_ready(fetch_ready),
        .br0_en(br0_en), .br0_imm(br0_imm), .br1_en(br1_en), .br1_imm(br1_imm),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .pc(pc), .fetch_valid(fetch_valid), .slot1_valid(slot1_valid),
        .pred_taken0(pred_taken0), .pred_taken1(pred_taken1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs are driven and outputs sampled 2ns after the edge.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic redirect_to(input logic [31:0] a);
        redirect_valid = 1'b1;
        redirect_pc    = a;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic train(input logic [31:0] a, input logic t);
        upd_valid = 1'b1;
        upd_pc    = a;
        upd_taken = t;
        tick();
        upd_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; fetch_ready = 1'b1;
        br0_en = 1'b0; br1_en = 1'b0; br0_imm = '0; br1_imm = '0;
        redirect_valid = 1'b0; redirect_pc = '0;
        upd_valid = 1'b0; upd_pc = '0; upd_taken = 1'b0;
        #12;
        chk("rst_pc", pc, 32'h100);
        chk("rst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("rst_s1", {31'd0, slot1_valid}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("boot_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("run_pc0", pc, 32'h100);
        chk("run_fv", {31'd0, fetch_valid}, 32'd1);
        chk("run_s1", {31'd0, slot1_valid}, 32'd1);
        tick();
        chk("run_pc1", pc, 32'h108);
        tick();
        chk("run_pc2", pc, 32'h110);

        // Train entry 0 (0x200) to strongly taken, predict slot 0 backward branch.
        train(32'h200, 1'b1);
        train(32'h200, 1'b1);
        redirect_to(32'h200);
        chk("fl_pc", pc, 32'h200);
        chk("fl_fv", {31'd0, fetch_valid}, 32'd0);
        br0_en = 1'b1; br0_imm = -32'sd16;
        #1;
        chk("fl_pt0_masked", {31'd0, pred_taken0}, 32'd0);
        tick();
        chk("s0_fv", {31'd0, fetch_valid}, 32'd1);
        chk("s0_pt0", {31'd0, pred_taken0}, 32'd1);
        chk("s0_s1", {31'd0, slot1_valid}, 32'd0);
        tick();
        br0_en = 1'b0;
        chk("s0_tgt", pc, 32'h1F0);

        // Slot 1 prediction: entry 1 (0x304) trained taken.
        train(32'h304, 1'b1);
        train(32'h304, 1'b1);
        redirect_to(32'h300);
        tick();
        br1_en = 1'b1; br1_imm = 32'h40;
        #1;
        chk("s1_pt1", {31'd0, pred_taken1}, 32'd1);
        chk("s1_pt0", {31'd0, pred_taken0}, 32'd0);
        chk("s1_s1v", {31'd0, slot1_valid}, 32'd1);
        tick();
        br1_en = 1'b0;
        chk("s1_tgt", pc, 32'h344);

        // Stall holds, then redirect during the stall.
        fetch_ready = 1'b0;
        tick();
        chk("stall_pc", pc, 32'h344);
        chk("stall_fv", {31'd0, fetch_valid}, 32'd1);
        redirect_to(32'h403);
        chk("rds_pc", pc, 32'h400);
        chk("rds_fv", {31'd0, fetch_valid}, 32'd0);
        tick();
        chk("rds_fv2", {31'd0, fetch_valid}, 32'd1);
        chk("rds_pc2", pc, 32'h400);

        // Saturation on entry 2 (0x408) while stalled at 0x408.
        fetch_ready = 1'b1;
        redirect_to(32'h408);
        tick();
        fetch_ready = 1'b0;
        br0_en = 1'b1; br0_imm = 32'h20;
        upd_valid = 1'b1; upd_pc = 32'h408; upd_taken = 1'b1;
        #1;
        chk("same_cyc_old", {31'd0, pred_taken0}, 32'd0);
        tick();
        chk("upd_vis", {31'd0, pred_taken0}, 32'd1);
        tick(); tick(); tick(); tick();
        upd_taken = 1'b0;
        tick();
        upd_valid = 1'b0;
        chk("sat_10", {31'd0, pred_taken0}, 32'd1);
        chk("sat_hold_pc", pc, 32'h408);
        upd_valid = 1'b1;
        #1;
        chk("same_cyc_old2", {31'd0, pred_taken0}, 32'd1);
        tick();
        upd_valid = 1'b0;
        chk("dec_01", {31'd0, pred_taken0}, 32'd0);
        fetch_ready = 1'b1;
        tick();
        br0_en = 1'b0;
        chk("nt_seq", pc, 32'h410);

        // Wrap-around.
        redirect_to(32'hFFFF_FFF8);
        chk("wrap_pc0", pc, 32'hFFFF_FFF8);
        tick();
        chk("wrap_fv", {31'd0, fetch_valid}, 32'd1);
        tick();
        chk("wrap_pc1", pc, 32'h0000_0000);

        // Async reset mid-run with pending redirect and update discarded.
        redirect_valid = 1'b1; redirect_pc = 32'h800;
        upd_valid = 1'b1; upd_pc = 32'h100; upd_taken = 1'b1;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h100);
        chk("arst_fv", {31'd0, fetch_valid}, 32'd0);
        chk("arst_pt", {30'd0, pred_taken0, pred_taken1}, 32'd0);
        tick();
        redirect_valid = 1'b0; upd_valid = 1'b0;
        chk("arst_hold", pc, 32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        br0_en = 1'b1; br0_imm = 32'h40;
        #1;
        chk("arst_bht", {31'd0, pred_taken0}, 32'd0);
        chk("arst_run_pc", pc, 32'h100);
        tick();
        br0_en = 1'b0;
        chk("arst_seq", pc, 32'h108);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/fetch_pc_sequencer.md
# fetch_pc_sequencer

Next-PC controller for the two-wide fetch stage. It holds the fetch PC and presents a two-instruction bundle address (slots at `pc` and `pc+4`) to instruction memory. It takes the per-slot branch predecode results (branch flag plus sign-extended B-type offset) and a 2-bit-counter branch history table (BHT) to pick the next PC. It also handles execute-stage redirects, BHT training and decode backpressure.

## Interface
- `RESET_PC`, 32'h0000_0000: first fetch address after reset.
- `BHT_IDX_W`, 4: BHT index width; 2**`BHT_IDX_W` entries.

- `clk`  in  1  clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `fetch_ready`  in  1  decode accepts the current bundle this cycle.
- `br0_en`  in  1  slot 0 predecoded as conditional branch.
- `br0_imm`  in  32  slot 0 offset, sign-extended.
- `br1_en`  in  1  slot 1 predecoded as conditional branch.
- `br1_imm`  in  32  slot 1 offset, sign-extended.
- `redirect_valid`  in  1  execute misprediction or flush.
- `redirect_pc`  in  32  corrected fetch address.
- `upd_valid`  in  1  resolved conditional branch, trains the BHT.
- `upd_pc`  in  32  address of the resolved branch.
- `upd_taken`  in  1  actual outcome.
- `pc`  out  32  current bundle base address.
- `fetch_valid`  out  1  bundle at `pc` is valid for decode.
- `slot1_valid`  out  1  slot 1 is part of the valid bundle.
- `pred_taken0`  out  1  slot 0 predicted taken.
- `pred_taken1`  out  1  slot 1 predicted taken.

## Operation
- FSM states:
  - BOOT: the cycle after reset release; `fetch_valid`=0.
  - RUN.
  - FLUSH: one bubble cycle after a redirect; `fetch_valid`=0.
- Transitions:
  - BOOT -> RUN unconditionally.
  - RUN -> FLUSH when `redirect_valid`.
  - FLUSH -> RUN, or FLUSH again if `redirect_valid`.
  - Any state -> FLUSH on `redirect_valid`.
- BHT: 2-bit saturating counters, all reset to 2'b01 (weakly not-taken). Predict taken when counter[1]=1.
- Lookup index: slot 0 uses `pc[BHT_IDX_W+1:2]`; slot 1 uses `(pc+4)[BHT_IDX_W+1:2]`.
- Lookup outputs (combinational):
  - `pred_taken0` = `br0_en` & bht0[1].
  - `pred_taken1` = `br1_en` & bht1[1] & ~`pred_taken0`.
  - Both are forced to 0 when `fetch_valid`=0.
- `slot1_valid` = `fetch_valid` & ~`pred_taken0`.
- Next-PC priority, highest first:
  1. `redirect_valid` -> `{redirect_pc[31:2],2'b00}`.
  2. State not RUN (BOOT/FLUSH) -> hold `pc`.
  3. `fetch_ready`=0 -> hold `pc`.
  4. `pred_taken0` -> `pc + br0_imm`.
  5. `pred_taken1` -> `pc + 4 + br1_imm`.
  6. Otherwise `pc + 8`.
- All PC arithmetic is 32-bit modulo 2**32; 32'hFFFF_FFF8 + 8 wraps to 0.
- Redirect is honoured even when `fetch_ready`=0.
- Training on `upd_valid`: the counter at `upd_pc[BHT_IDX_W+1:2]` increments (taken) or decrements (not taken), saturating at 3 and 0.
- Training is independent of state, stall and redirect.
- If an update and a lookup hit the same entry in the same cycle, the lookup sees the pre-update value.

## Timing
- Reset (async, `rst_n`=0):
  - `pc`=`RESET_PC`, state=BOOT, all BHT entries=2'b01.
  - `fetch_valid`=0, `slot1_valid`=0, `pred_taken0`=0, `pred_taken1`=0.
- Reset asserted mid-operation aborts immediately. A pending redirect or update in that cycle is discarded.
- `br*_en`/`br*_imm` are combinational from instruction memory at the current `pc`, same cycle.
- `pc` updates on the clock edge. Prediction-to-redirected-fetch latency is 1 cycle, with no bubble for predicted-taken branches.
- Redirect latency:
  - Cycle N: `redirect_valid`.
  - N+1: `pc`=`redirect_pc`, FLUSH, `fetch_valid`=0.
  - N+2: RUN, `fetch_valid`=1.
- BHT training: the updated value is visible to lookups from the cycle after `upd_valid`.
- Bundle handshake: a bundle is consumed when `fetch_valid`&`fetch_ready`. While `fetch_ready`=0, `pc` and all outputs hold stable.

## Test plan
- Reset, `RESET_PC`=0x100, `fetch_ready`=1, no branches:
  - First edge after release: `fetch_valid`=0.
  - Following cycles: `pc`=0x100, 0x108, 0x110; `slot1_valid`=1.
- Train entry for 0x200 with two `upd_taken`=1; then fetch `pc`=0x200, `br0_en`=1, `br0_imm`=-16:
  - `pred_taken0`=1, `slot1_valid`=0.
  - Next `pc`=0x1F0.
- Slot 1 prediction at `pc`=0x300: slot 1 branch with trained taken counter, `br1_imm`=0x40 -> `pred_taken1`=1, next `pc`=0x344.
- Redirect during a stall: `fetch_ready`=0 and `redirect_valid`=1 with `redirect_pc`=0x403:
  - Next `pc`=0x400, `fetch_valid`=0 for one cycle, then 1.
- Counter saturation: five `upd_taken`=1 then one `upd_taken`=0 on the same entry -> counter 2'b10, predicts taken.
  - Same-cycle update and lookup of that entry uses the old value.
- Wrap: `redirect_pc`=0xFFFF_FFF8, no branches -> sequence 0xFFFF_FFF8, 0x0000_0000.
  - Assert `rst_n`=0 mid-run -> outputs reset immediately, without waiting for a clock edge.
